onehot_seq_monitor: RTL and testbench

- Checker stage directly downstream of the 1→2→4→8→1 one-hot sequence counter.
- Samples the counter's output every clock and mirrors its load strobe.
- Verifies each transition against the legal rotation and locks onto the sequence.
- Counts completed laps (8→1) and records transition faults for the status/debug logic.

---
 rtl/onehot_seq_pkg.sv | 31 +++
 rtl/onehot_seq_monitor.sv | 137 +++++++++++++
 tb/tb_onehot_seq_monitor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/onehot_seq_pkg.sv
// Shared types and helpers for the one-hot sequence monitor: state encoding,
// sequence endpoints and the 1->2->4->8->1 successor function.
package onehot_seq_pkg;

    localparam int unsigned SEQ_W = 4;

    localparam logic [SEQ_W-1:0] SEQ_FIRST = 4'd1;
    localparam logic [SEQ_W-1:0] SEQ_LAST  = 4'd8;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        FAULT
    } state_e;

    function automatic logic is_onehot_legal(input logic [SEQ_W-1:0] value);
        return (value == 4'd1) || (value == 4'd2) || (value == 4'd4) || (value == 4'd8);
    endfunction

    // Returns 0 for any value outside the rotation, so 0 never matches a legal successor.
    function automatic logic [SEQ_W-1:0] next_onehot(input logic [SEQ_W-1:0] value);
        case (value)
            4'd1:    return 4'd2;
            4'd2:    return 4'd4;
            4'd4:    return 4'd8;
            4'd8:    return 4'd1;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/onehot_seq_monitor.sv
// Monitors a 1->2->4->8->1 one-hot counter: locks on, counts laps, records faults.
// Define SEQMON_HOLD_EN to accept a repeated one-hot value as a legal hold.
module onehot_seq_monitor
    import onehot_seq_pkg::*;
#(
    parameter int unsigned N_BITS   = SEQ_W,
    parameter int unsigned LOCK_RUN = 2,
    parameter int unsigned LAP_W    = 8,
    parameter int unsigned ERR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [N_BITS-1:0] count_in,
    input  logic              clear_err,
    output logic              locked,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_count,
    output logic [LAP_W-1:0]  lap_count
);

    state_e             state_q, state_d;
    logic [N_BITS-1:0]  prev_q;
    logic               prev_v_q;
    logic               load_dly_q;
    logic [2:0]         run_q, run_d;
    logic [2:0]         run_inc;
    logic               err_flag_q, err_flag_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [LAP_W-1:0]   lap_count_q, lap_count_d;

    logic [N_BITS-1:0]  succ;
    logic               legal;
    logic               hold;
    logic               lap_step;
    logic               fault;

    always_comb begin
        succ     = next_onehot(prev_q);
        legal    = prev_v_q && (succ != '0) && (count_in == succ);
`ifdef SEQMON_HOLD_EN
        hold     = prev_v_q && (count_in == prev_q) && is_onehot_legal(prev_q);
`else
        hold     = 1'b0;
`endif
        lap_step = (prev_q == SEQ_LAST) && (count_in == SEQ_FIRST);
        run_inc  = run_q + 3'd1;
    end

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
        lap_count_d = lap_count_q;
        fault       = 1'b0;

        unique case (state_q)
            UNLOCKED: begin
                if (load_dly_q || !(legal || hold)) begin
                    run_d = '0;
                end else if (legal) begin
                    if (run_inc == 3'(LOCK_RUN)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
            end
            LOCKED: begin
                // A load one cycle earlier excuses any jump, but only to a one-hot value.
                if (load_dly_q) begin
                    if (!is_onehot_legal(count_in)) begin
                        state_d = UNLOCKED;
                    end
                end else if (legal) begin
                    if (lap_step) begin
                        lap_count_d = lap_count_q + 1'b1;
                    end
                end else if (!hold) begin
                    state_d = FAULT;
                    fault   = 1'b1;
                end
            end
            FAULT: begin
                state_d = UNLOCKED;
                run_d   = '0;
            end
            default: begin
                state_d = UNLOCKED;
                run_d   = '0;
            end
        endcase

        // A fault on the clearing edge wins and leaves a count of exactly one.
        if (fault) begin
            err_flag_d = 1'b1;
            if (clear_err) begin
                err_count_d = ERR_W'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end else if (clear_err) begin
            err_flag_d  = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNLOCKED;
            prev_q      <= '0;
            prev_v_q    <= 1'b0;
            load_dly_q  <= 1'b0;
            run_q       <= '0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            lap_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= count_in;
            prev_v_q    <= 1'b1;
            load_dly_q  <= load;
            run_q       <= run_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
            lap_count_q <= lap_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;
    assign lap_count = lap_count_q;

endmodule

// File: tb/tb_onehot_seq_monitor.sv
// Scoreboard bench for onehot_seq_monitor: directed scenarios then random traffic,
// each checked against a behavioural model (honours SEQMON_HOLD_EN).
module tb_onehot_seq_monitor;

`ifdef SEQMON_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam int LOCK_RUN = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic       clear_err = 1'b0;
    logic       locked;
    logic       err_flag;
    logic [3:0] err_count;
    logic [7:0] lap_count;

    onehot_seq_monitor #(
        .N_BITS   (4),
        .LOCK_RUN (LOCK_RUN),
        .LAP_W    (8),
        .ERR_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .count_in  (count_in),
        .clear_err (clear_err),
        .locked    (locked),
        .err_flag  (err_flag),
        .err_count (err_count),
        .lap_count (lap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit lk;
        bit ef;
        int ec;
        int lc;
        int step;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_step  = 0;

    // Behavioural model state
    int m_prev = 0;
    bit m_pv = 0, m_ld = 0, m_locked = 0, m_fault = 0, m_eflag = 0;
    int m_streak = 0, m_errs = 0, m_laps = 0;

    function automatic int m_next(int v);
        if (v == 8) return 1;
        if (v == 1 || v == 2 || v == 4) return v * 2;
        return 0;
    endfunction

    function automatic bit m_onehot(int v);
        return (v > 0) && (v < 16) && ($countones(v) == 1);
    endfunction

    task automatic chk(input string name, input int stp, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at step %0d: got %0d, expected %0d", name, stp, act, exp);
    endtask

    // Drive one cycle of inputs, advance the model and queue the expected outputs.
    task automatic step(input bit r, input bit ld, input int cin, input bit clr);
        bit   legal, hold, flt;
        exp_t e;
        @(negedge clk);
        reset     = r;
        load      = ld;
        count_in  = 4'(cin);
        clear_err = clr;
        n_step++;
        if (r) begin
            m_prev = 0; m_pv = 0; m_ld = 0; m_locked = 0; m_fault = 0;
            m_streak = 0; m_errs = 0; m_laps = 0; m_eflag = 0;
        end else begin
            legal = m_pv && (m_next(m_prev) != 0) && (cin == m_next(m_prev));
            hold  = HOLD && m_pv && (cin == m_prev) && m_onehot(m_prev);
            flt   = 0;
            if (m_fault) begin
                m_fault = 0;
                m_streak = 0;
            end else if (!m_locked) begin
                if (m_ld || !(legal || hold)) m_streak = 0;
                else if (legal) begin
                    m_streak++;
                    if (m_streak == LOCK_RUN) begin
                        m_locked = 1;
                        m_streak = 0;
                    end
                end
            end else if (m_ld) begin
                if (!m_onehot(cin)) m_locked = 0;
            end else if (legal) begin
                if (m_prev == 8 && cin == 1) m_laps = (m_laps + 1) % 256;
            end else if (!hold) begin
                m_locked = 0;
                m_fault  = 1;
                flt      = 1;
            end
            if (flt) begin
                m_eflag = 1;
                m_errs  = clr ? 1 : ((m_errs < 15) ? m_errs + 1 : 15);
            end else if (clr) begin
                m_eflag = 0;
                m_errs  = 0;
            end
            m_prev = cin;
            m_pv   = 1;
            m_ld   = ld;
        end
        e.lk = m_locked; e.ef = m_eflag; e.ec = m_errs; e.lc = m_laps; e.step = n_step;
        exp_q.push_back(e);
    endtask

    task automatic seq(input int a, input int b, input int c);
        step(0, 0, a, 0);
        step(0, 0, b, 0);
        step(0, 0, c, 0);
    endtask

    // Monitor: outputs are valid one edge after each driven sample.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("locked",    e.step, int'(locked),    int'(e.lk));
                chk("err_flag",  e.step, int'(err_flag),  int'(e.ef));
                chk("err_count", e.step, int'(err_count), e.ec);
                chk("lap_count", e.step, int'(lap_count), e.lc);
            end
        end
    end

    initial begin
        int p, cin;
        bit rst, ld, clr;

        // Reset, then lock on 1,2,4
        step(1, 0, 0, 0);
        seq(1, 2, 4);
        // Two laps
        seq(8, 1, 2);
        seq(4, 8, 1);
        // Skip from 2 to 8, then relock
        step(0, 0, 2, 0);
        step(0, 0, 8, 0);
        seq(1, 2, 4);
        // Load-excused jump to a one-hot value, then to an illegal one
        step(0, 1, 8, 0);
        step(0, 0, 2, 0);
        step(0, 0, 4, 0);
        step(0, 1, 8, 0);
        step(0, 0, 3, 0);
        seq(1, 2, 4);
        // 17 faults with relock between each, exercising saturation
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 2, 0);
            seq(1, 2, 4);
        end
        step(0, 0, 8, 1);
        step(0, 0, 8, 0);
        step(0, 0, 1, 1);
        seq(2, 4, 8);
        step(0, 0, 2, 1);
        seq(1, 2, 4);
        // Hold at 4 for two cycles
        step(0, 0, 4, 0);
        step(0, 0, 4, 0);
        seq(8, 1, 2);
        seq(4, 8, 1);
        // Mid-lock reset
        step(1, 0, 2, 0);
        seq(1, 2, 4);

        // Random traffic, mostly following the rotation
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) < 1);
            ld  = ($urandom_range(0, 99) < 6);
            clr = ($urandom_range(0, 99) < 5);
            p   = $urandom_range(0, 99);
            if (p < 8) cin = $urandom_range(0, 15);
            else if (p < 14) cin = m_prev;
            else cin = (m_next(m_prev) != 0) ? m_next(m_prev) : 1;
            step(rst, ld, cin, clr);
        end

        @(negedge clk);
        reset = 1'b0; load = 1'b0; clear_err = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
